// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU control codes shared by the ALU control decode and the EX multiplier, plus the multiplier FSM states.
package cpu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_FIX, MUL_DONE} mul_state_e;
endpackage

// File: rtl/mul_datapath.sv
// mul_datapath: magnitude shift-add multiplier datapath with final sign fix-up.
// Ports: clk_i/rst_i (sync active-high); load_i captures operand magnitudes and sign;
// step_i performs one radix-2 iteration; fix_i applies the sign and loads product_o;
// last_o flags the final iteration; product_o holds the last signed product.
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               fix_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, fixed;
    logic [WIDTH-1:0]   mplier_q, mplier_d, mag1, mag2;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    // Unsigned magnitudes: the most negative value maps onto itself, which is its true magnitude.
    assign mag1  = src1_i[WIDTH-1] ? -src1_i : src1_i;
    assign mag2  = src2_i[WIDTH-1] ? -src2_i : src2_i;
    assign fixed = neg_q ? -acc_q : acc_q;
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, mag1};
            mplier_d = mag2;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            neg_d    = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
        end else if (step_i) begin
            // Shifting the multiplicand each step keeps it aligned to the current iteration index.
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end else if (fix_i) begin
            acc_d  = fixed;
            prod_d = fixed;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end
    assign last_o    = cnt_q == '0;
    assign product_o = prod_q;
endmodule

// File: rtl/ex_mul_unit.sv
// ex_mul_unit: iterative signed multiplier in EX that stalls the pipeline while a MUL runs.
// Ports: clk_i/rst_i (sync active-high); valid_i, alu_ctrl_i, src1_i, src2_i from the ALU
// decode; flush_i aborts an op in flight; product_o/result_o hold the last product;
// done_o pulses when it is ready; busy_o = FSM not idle; stall_o freezes IF/ID/EX.
module ex_mul_unit
    import cpu_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CTRL = ALU_MUL
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [3:0]         alu_ctrl_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    input  logic               flush_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               stall_o
);
    mul_state_e state_q, state_d;
    logic       is_mul, accept, step, fix, last;
    assign is_mul = valid_i && alu_ctrl_i == MUL_CTRL;
    assign accept = is_mul && state_q == MUL_IDLE && !flush_i;
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: state_d = accept ? MUL_RUN : MUL_IDLE;
            MUL_RUN:  state_d = last ? MUL_FIX : MUL_RUN;
            MUL_FIX:  state_d = MUL_DONE;
            default:  state_d = MUL_IDLE;
        endcase
        if (flush_i) state_d = state_q == MUL_IDLE ? state_d : MUL_IDLE;
        step    = state_q == MUL_RUN && !flush_i;
        fix     = state_q == MUL_FIX && !flush_i;
        done_o  = state_q == MUL_DONE;
        busy_o  = state_q != MUL_IDLE;
        stall_o = is_mul && !done_o && !flush_i;
    end
    always_ff @(posedge clk_i) state_q <= rst_i ? MUL_IDLE : state_d;
    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .step_i    (step),
        .fix_i     (fix),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .last_o    (last),
        .product_o (product_o)
    );
    assign result_o = product_o[WIDTH-1:0];
endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: scoreboard bench for ex_mul_unit with directed multiply, abort and pass-through vectors.
module tb_ex_mul_unit;
    import cpu_pkg::*;
    logic        clk = 0, rst = 1, valid = 0, flush = 0;
    logic [3:0]  ctrl = ALU_ADD;
    logic [31:0] s1 = 0, s2 = 0;
    logic [63:0] product_o;
    logic [31:0] result_o;
    logic        done_o, busy_o, stall_o;
    logic [63:0] sb[$];
    int vectors = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
    ex_mul_unit dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .alu_ctrl_i(ctrl),
        .src1_i(s1), .src2_i(s2), .flush_i(flush),
        .product_o(product_o), .result_o(result_o),
        .done_o(done_o), .busy_o(busy_o), .stall_o(stall_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL stray_done: got done_o=1 expected no pulse, product %h", product_o);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("product", product_o, e);
                check("result", {32'h0, result_o}, {32'h0, e[31:0]});
            end
        end
    end
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        int st, n;
        sb.push_back(e);
        valid = 1; ctrl = ALU_MUL; s1 = a; s2 = b; st = 0; n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (stall_o) st++;
            if (done_o || n > 100) break;
        end
        check("done_seen", {63'h0, done_o}, 64'h1);
        check("stall_cycles", 64'(st), 64'd34);
        @(posedge clk); #1;
    endtask
    task automatic abort(input bit use_rst);
        logic [63:0] p;
        int d0;
        p = product_o; d0 = done_cnt;
        valid = 1; ctrl = ALU_MUL; s1 = 32'd7; s2 = 32'd9;
        repeat (11) @(posedge clk);
        #1;
        check("busy_in_run", {63'h0, busy_o}, 64'h1);
        if (use_rst) begin
            rst = 1; valid = 0;
        end else begin
            flush = 1;
            @(negedge clk);
            check("stall_on_flush", {63'h0, stall_o}, 64'h0);
        end
        @(posedge clk); #1;
        rst = 0; flush = 0; valid = 0;
        @(negedge clk);
        check("abort_busy", {63'h0, busy_o}, 64'h0);
        check("abort_stall", {63'h0, stall_o}, 64'h0);
        check("abort_product", product_o, use_rst ? 64'h0 : p);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
    endtask
    initial begin
        int t1;
        logic [63:0] p;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("rst_product", product_o, 64'h0);
        check("rst_result", {32'h0, result_o}, 64'h0);
        check("rst_done", {63'h0, done_o}, 64'h0);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        @(posedge clk); #1;
        run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_mul(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        run_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_mul(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_mul(32'h0000_0000, 32'hFFFF_FFFB, 64'h0);
        run_mul(32'd2, 32'd3, 64'd6);
        t1 = done_cyc;
        run_mul(32'd4, 32'd5, 64'd20);
        check("b2b_spacing", 64'(done_cyc - t1), 64'd35);
        valid = 0;
        @(posedge clk); #1;
        abort(1'b1);
        run_mul(32'd3, 32'd5, 64'hF);
        valid = 0;
        @(posedge clk); #1;
        abort(1'b0);
        p = product_o;
        valid = 1; ctrl = ALU_ADD; s1 = 32'd11; s2 = 32'd13;
        repeat (8) begin
            @(negedge clk);
            check("nonmul_stall", {63'h0, stall_o}, 64'h0);
            check("nonmul_busy", {63'h0, busy_o}, 64'h0);
            check("nonmul_done", {63'h0, done_o}, 64'h0);
            check("nonmul_product", product_o, p);
        end
        valid = 0;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ex_mul_unit.md
Name: ex_mul_unit

Overview:
- Iterative signed multiplier in the EX stage, directly downstream of the ALU control decode.
- Consumes the 4-bit ALU control code together with the two ALU operands.
- When the code is MUL (4'b1000, from R-type funct 011000), it runs a radix-2 shift-add multiply over WIDTH cycles and stalls the pipeline until the product is ready.
- Any other code passes through untouched and causes no stall.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- MUL_CTRL, 4'b1000: ALU control code that selects multiply.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- valid_i  input  1  EX stage holds a live instruction.
- alu_ctrl_i  input  4  ALU control code from the ALU control decode.
- src1_i  input  WIDTH  multiplicand (rs value, two's complement).
- src2_i  input  WIDTH  multiplier (rt value, two's complement).
- flush_i  input  1  EX flush; aborts any multiply in flight.
- product_o  output  2*WIDTH  signed product; valid while done_o=1.
- result_o  output  WIDTH  product_o[WIDTH-1:0]; written back to rd.
- done_o  output  1  one-cycle pulse: product valid.
- busy_o  output  1  FSM not in IDLE.
- stall_o  output  1  freeze IF/ID/EX; combinational.

Behaviour:
- Reset: on rst_i=1 at a clock edge, go to IDLE and clear the accumulator, operand registers, counter and sign flag.
  - Outputs after reset: product_o=0, result_o=0, done_o=0, busy_o=0.
  - rst_i overrides every other input, including mid-operation; no done_o pulse is produced for an interrupted multiply.
- Accept condition: accept = valid_i & (alu_ctrl_i==MUL_CTRL) & state==IDLE & ~flush_i.
- stall_o = valid_i & (alu_ctrl_i==MUL_CTRL) & ~done_o & ~flush_i.
  - The instruction stays in EX, with operands held stable by the stall, until the done cycle.
- FSM states are IDLE, RUN, FIX and DONE.
- IDLE:
  - On accept, load |src1_i| into the multiplicand register and |src2_i| into the multiplier register, using unsigned WIDTH-bit magnitudes, so 0x80000000 has magnitude 0x80000000.
  - Set neg = src1_i[MSB] ^ src2_i[MSB], clear the 2*WIDTH accumulator, set cnt=WIDTH-1, and go to RUN.
- RUN:
  - Each edge: if the multiplier LSB is 1, add the zero-extended multiplicand shifted left by the iteration index into the accumulator.
  - Each edge: shift the multiplier right by 1 and decrement cnt.
  - When cnt==0, go to FIX. RUN lasts exactly WIDTH edges.
- FIX: one edge. If neg is set, the accumulator becomes its two's-complement negation; product_o is loaded from the accumulator. Go to DONE.
- DONE: done_o=1 for exactly one cycle and stall_o drops, so the pipeline advances at the next edge. Return to IDLE unconditionally.
- Latency: accepted at edge E0, RUN at E1..E32, FIX at E33, done_o high in the cycle after E33, IDLE after E34. Total 34 cycles of stall for WIDTH=32.
- Back-to-back multiplies: the next MUL reaches EX after E34 and is accepted from IDLE with no bubble beyond its own latency.
- flush_i=1 in any state other than IDLE: return to IDLE at the next edge with no done_o pulse; product_o keeps its previous value.
- done_o never pulses outside DONE. product_o and result_o hold their value until the next FIX.
- Non-MUL codes: no state change, stall_o=0, outputs unchanged.
- All arithmetic is modulo 2^(2*WIDTH). The magnitude product is at most 2^62, so the negation never overflows.

Decomposition:
- Shared cpu_pkg holds:
  - ALU control code constants: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, MUL 1000. The ALU control decode and this unit both import them.
  - FSM state encoding for this unit.
- One sub-module is natural: mul_datapath.
  - Contains the magnitude conversion, accumulator, shift registers and final negation.
  - Controlled by load/step/fix strobes from the FSM in ex_mul_unit.

Test Plan:
- src1=3, src2=5, MUL → stall_o high for 34 cycles; done_o pulses once; product_o=0x000000000000000F; result_o=0x0000000F.
- src1=-7 (0xFFFFFFF9), src2=6 → product_o=0xFFFFFFFFFFFFFFD6; result_o=0xFFFFFFD6.
- src1=src2=0x80000000 → product_o=0x4000000000000000. src1=src2=0xFFFFFFFF → product_o=0x0000000000000001.
- Two MULs back-to-back (2×3, then 4×5) → two done_o pulses 35 cycles apart with products 6 and 20; no stray accept in the DONE cycle.
- rst_i asserted in RUN cycle 10 → IDLE, busy_o=0, stall_o=0, no done_o, product_o=0.
- Separately, flush_i asserted in RUN → IDLE with no done_o.
- valid_i=1 with alu_ctrl_i=0010 → stall_o=0 and busy_o=0 throughout; outputs unchanged.
